// File: rtl/sensor_link_pkg.sv
// sensor_link_pkg: shared frame layout and arbiter state types for the sensor link arbiter
package sensor_link_pkg;
  localparam int FRAME_W = 96;
  localparam int ROLL_MSB = 95, ROLL_LSB = 80, PITCH_MSB = 79, PITCH_LSB = 64;
  localparam int YAW_MSB = 63, YAW_LSB = 48, GYRO_X_MSB = 47, GYRO_X_LSB = 32;
  localparam int GYRO_Y_MSB = 31, GYRO_Y_LSB = 16, GYRO_Z_MSB = 15, GYRO_Z_LSB = 0;
  typedef struct packed {
    logic [15:0] roll;
    logic [15:0] pitch;
    logic [15:0] yaw;
    logic [15:0] gyro_x;
    logic [15:0] gyro_y;
    logic [15:0] gyro_z;
  } sensor_frame_t;
  typedef enum logic {IDLE, OFFER} arb_state_t;
endpackage

// File: rtl/link_watchdog.sv
// link_watchdog: per-link freshness counter; alive once a frame was seen and the last one is under TIMEOUT_CYCLES old
// ports: clk, rst_n (async active-low), pulse (frame arrived), alive (registered freshness flag)
module link_watchdog #(
  parameter int TIMEOUT_CYCLES = 960000,
  parameter int CNT_W = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse,
  output logic alive
);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt, cnt_n;
  logic seen;
  assign cnt_n = pulse ? '0 : (cnt == LIM ? cnt : cnt + 1'b1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      seen <= 1'b0;
      alive <= 1'b0;
    end else begin
      cnt <= cnt_n;
      seen <= seen | pulse;
      alive <= (seen | pulse) && (cnt_n < LIM);
    end
  end
endmodule

// File: rtl/sensor_link_arbiter.sv
// sensor_link_arbiter: one-deep per-link frame slots, round-robin grant onto a valid/ready port, watchdog and overrun stats
// ports: clk, rst_n (async active-low); link_valid/link_frame/link_flags per link in;
//        out_valid/out_ready/out_link_id/out_frame/out_flags downstream; link_alive, link_overrun, drop_count, clear_stats
module sensor_link_arbiter import sensor_link_pkg::*; #(
  parameter int NUM_LINKS = 2,
  parameter int FRAME_W = sensor_link_pkg::FRAME_W,
  parameter int TIMEOUT_CYCLES = 960000,
  parameter int CNT_W = 20
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_LINKS-1:0]           link_valid,
  input  logic [NUM_LINKS*FRAME_W-1:0]   link_frame,
  input  logic [NUM_LINKS*2-1:0]         link_flags,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [2:0]                     out_link_id,
  output logic [FRAME_W-1:0]             out_frame,
  output logic [1:0]                     out_flags,
  output logic [NUM_LINKS-1:0]           link_alive,
  output logic [NUM_LINKS-1:0]           link_overrun,
  output logic [NUM_LINKS*8-1:0]         drop_count,
  input  logic                           clear_stats
);
  localparam int IW = NUM_LINKS > 1 ? $clog2(NUM_LINKS) : 1;
  arb_state_t state, state_n;
  logic [NUM_LINKS-1:0] pend, gnt_vec, ovr;
  logic [FRAME_W-1:0] slot_frame [NUM_LINKS];
  logic [1:0] slot_flags [NUM_LINKS];
  logic [IW-1:0] rr_ptr, gnt_idx;
  logic gnt_en;
  // descending scan so the pending link closest to rr_ptr is the one left standing
  always_comb begin
    gnt_en = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_LINKS - 1; k >= 0; k--)
      if (pend[IW'((int'(rr_ptr) + k) % NUM_LINKS)]) begin
        gnt_en = 1'b1;
        gnt_idx = IW'((int'(rr_ptr) + k) % NUM_LINKS);
      end
    gnt_en = gnt_en && (state == IDLE || out_ready);
  end
  assign gnt_vec = gnt_en ? (NUM_LINKS'(1) << gnt_idx) : '0;
  // a slot being granted this cycle hands its old frame out, so a new pulse there is not an overrun
  assign ovr = link_valid & pend & ~gnt_vec;
  assign state_n = (gnt_en || (state == OFFER && !out_ready)) ? OFFER : IDLE;
  assign out_valid = (state == OFFER);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      rr_ptr <= '0;
      out_link_id <= '0;
      out_frame <= '0;
      out_flags <= '0;
      link_overrun <= '0;
      drop_count <= '0;
      for (int i = 0; i < NUM_LINKS; i++) begin
        slot_frame[i] <= '0;
        slot_flags[i] <= '0;
      end
    end else begin
      pend <= link_valid | (pend & ~gnt_vec);
      link_overrun <= (clear_stats ? '0 : link_overrun) | ovr;
      for (int i = 0; i < NUM_LINKS; i++) begin
        if (link_valid[i]) begin
          slot_frame[i] <= link_frame[i*FRAME_W +: FRAME_W];
          slot_flags[i] <= link_flags[i*2 +: 2];
        end
        drop_count[i*8 +: 8] <= clear_stats ? {7'd0, ovr[i]}
          : drop_count[i*8 +: 8] + {7'd0, ovr[i] && drop_count[i*8 +: 8] != 8'hFF};
      end
      if (gnt_en) begin
        out_frame <= slot_frame[gnt_idx];
        out_flags <= slot_flags[gnt_idx];
        out_link_id <= 3'(gnt_idx);
        rr_ptr <= IW'((int'(gnt_idx) + 1) % NUM_LINKS);
      end
    end
  end
  for (genvar i = 0; i < NUM_LINKS; i++) begin : g_wd
    link_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) u_wd (
      .clk(clk),
      .rst_n(rst_n),
      .pulse(link_valid[i]),
      .alive(link_alive[i])
    );
  end
endmodule

// File: tb/tb_sensor_link_arbiter.sv
// tb_sensor_link_arbiter: directed self-checking bench for sensor_link_arbiter
module tb_sensor_link_arbiter;
  import sensor_link_pkg::*;
  localparam int N = 2;
  localparam int FW = 96;
  logic clk = 1'b0, rst_n = 1'b0, out_ready = 1'b0, clear_stats = 1'b0;
  logic [N-1:0] link_valid = '0;
  logic [N*FW-1:0] link_frame = '0;
  logic [N*2-1:0] link_flags = '0;
  logic out_valid;
  logic [2:0] out_link_id;
  logic [FW-1:0] out_frame;
  logic [1:0] out_flags;
  logic [N-1:0] link_alive, link_overrun;
  logic [N*8-1:0] drop_count;
  int pass = 0, total = 0;
  always #5 clk = ~clk;
  sensor_link_arbiter #(.NUM_LINKS(N), .FRAME_W(FW), .TIMEOUT_CYCLES(100), .CNT_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .link_valid(link_valid), .link_frame(link_frame), .link_flags(link_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_link_id(out_link_id), .out_frame(out_frame),
    .out_flags(out_flags), .link_alive(link_alive), .link_overrun(link_overrun),
    .drop_count(drop_count), .clear_stats(clear_stats)
  );
  function automatic logic [FW-1:0] mk(input logic [15:0] r, input logic [15:0] z);
    sensor_frame_t f;
    f = '0;
    f.roll = r;
    f.gyro_z = z;
    return f;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [N-1:0] m, input logic [FW-1:0] f0, input logic [FW-1:0] f1,
                      input logic [1:0] fl0, input logic [1:0] fl1);
    link_valid = m;
    link_frame = {f1, f0};
    link_flags = {fl1, fl0};
    tick();
    link_valid = '0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    clear_stats = 1'b0;
    link_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", out_valid); else pass++;
    total++; if (out_link_id !== 3'd0) $display("FAIL rst_id got %0d want 0", out_link_id); else pass++;
    total++; if (out_frame !== '0) $display("FAIL rst_frame got %h want 0", out_frame); else pass++;
    total++; if (out_flags !== 2'b00) $display("FAIL rst_flags got %b want 00", out_flags); else pass++;
    total++; if (link_alive !== 2'b00) $display("FAIL rst_alive got %b want 00", link_alive); else pass++;
    total++; if (link_overrun !== 2'b00) $display("FAIL rst_overrun got %b want 00", link_overrun); else pass++;
    total++; if (drop_count !== 16'h0) $display("FAIL rst_drop got %h want 0", drop_count); else pass++;
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_latency();
    send(2'b01, mk(16'h1234, 16'hBEEF), '0, 2'b11, 2'b00);
    total++; if (out_valid !== 1'b0) $display("FAIL lat_early got %b want 0", out_valid); else pass++;
    total++; if (link_alive !== 2'b01) $display("FAIL lat_alive got %b want 01", link_alive); else pass++;
    tick();
    total++; if (out_valid !== 1'b1) $display("FAIL lat_valid got %b want 1", out_valid); else pass++;
    total++; if (out_link_id !== 3'd0) $display("FAIL lat_id got %0d want 0", out_link_id); else pass++;
    total++; if (out_frame !== mk(16'h1234, 16'hBEEF)) $display("FAIL lat_frame got %h want %h", out_frame, mk(16'h1234, 16'hBEEF)); else pass++;
    total++; if (out_flags !== 2'b11) $display("FAIL lat_flags got %b want 11", out_flags); else pass++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL lat_drain got %b want 0", out_valid); else pass++;
  endtask
  task automatic test_overrun();
    send(2'b01, mk(16'hA, 16'h1), '0, 2'b01, 2'b00);
    tick();
    send(2'b01, mk(16'hB, 16'h2), '0, 2'b01, 2'b00);
    send(2'b01, mk(16'hC, 16'h3), '0, 2'b01, 2'b00);
    send(2'b01, mk(16'hD, 16'h4), '0, 2'b10, 2'b00);
    total++; if (drop_count[7:0] !== 8'd2) $display("FAIL ovr_drop got %0d want 2", drop_count[7:0]); else pass++;
    total++; if (link_overrun !== 2'b01) $display("FAIL ovr_flag got %b want 01", link_overrun); else pass++;
    total++; if (out_frame !== mk(16'hA, 16'h1)) $display("FAIL ovr_first got %h want %h", out_frame, mk(16'hA, 16'h1)); else pass++;
    clear_stats = 1'b1;
    send(2'b01, mk(16'hE, 16'h5), '0, 2'b11, 2'b00);
    clear_stats = 1'b0;
    total++; if (link_overrun !== 2'b01) $display("FAIL clr_ovr_flag got %b want 01", link_overrun); else pass++;
    total++; if (drop_count[7:0] !== 8'd1) $display("FAIL clr_ovr_drop got %0d want 1", drop_count[7:0]); else pass++;
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    total++; if (link_overrun !== 2'b00) $display("FAIL clr_flag got %b want 00", link_overrun); else pass++;
    total++; if (drop_count !== 16'h0) $display("FAIL clr_drop got %h want 0", drop_count); else pass++;
    out_ready = 1'b1;
    tick();
    total++; if (out_frame !== mk(16'hE, 16'h5) || out_valid !== 1'b1) $display("FAIL ovr_newest got %h/%b want %h/1", out_frame, out_valid, mk(16'hE, 16'h5)); else pass++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL ovr_idle got %b want 0", out_valid); else pass++;
    out_ready = 1'b0;
  endtask
  task automatic test_round_robin();
    do_reset();
    out_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      send(2'b11, mk(16'(r), 16'h10), mk(16'(r), 16'h20), 2'b01, 2'b10);
      tick();
      total++; if (out_valid !== 1'b1 || out_link_id !== 3'd0) $display("FAIL rr_first r%0d got %b/%0d want 1/0", r, out_valid, out_link_id); else pass++;
      total++; if (out_frame !== mk(16'(r), 16'h10)) $display("FAIL rr_frame0 r%0d got %h want %h", r, out_frame, mk(16'(r), 16'h10)); else pass++;
      tick();
      total++; if (out_valid !== 1'b1 || out_link_id !== 3'd1) $display("FAIL rr_second r%0d got %b/%0d want 1/1", r, out_valid, out_link_id); else pass++;
      total++; if (out_frame !== mk(16'(r), 16'h20) || out_flags !== 2'b10) $display("FAIL rr_frame1 r%0d got %h/%b want %h/10", r, out_frame, out_flags, mk(16'(r), 16'h20)); else pass++;
      tick();
      total++; if (out_valid !== 1'b0) $display("FAIL rr_idle r%0d got %b want 0", r, out_valid); else pass++;
    end
    out_ready = 1'b0;
  endtask
  task automatic test_back_to_back();
    do_reset();
    send(2'b10, '0, mk(16'h5, 16'h50), 2'b00, 2'b01);
    send(2'b10, '0, mk(16'h6, 16'h60), 2'b00, 2'b11);
    total++; if (out_valid !== 1'b1 || out_link_id !== 3'd1) $display("FAIL b2b_offer got %b/%0d want 1/1", out_valid, out_link_id); else pass++;
    total++; if (out_frame !== mk(16'h5, 16'h50)) $display("FAIL b2b_old got %h want %h", out_frame, mk(16'h5, 16'h50)); else pass++;
    total++; if (link_overrun !== 2'b00 || drop_count !== 16'h0) $display("FAIL b2b_noovr got %b/%h want 00/0", link_overrun, drop_count); else pass++;
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b1 || out_frame !== mk(16'h6, 16'h60) || out_flags !== 2'b11) $display("FAIL b2b_new got %b/%h/%b want 1/%h/11", out_valid, out_frame, out_flags, mk(16'h6, 16'h60)); else pass++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL b2b_idle got %b want 0", out_valid); else pass++;
    out_ready = 1'b0;
  endtask
  task automatic test_watchdog();
    do_reset();
    out_ready = 1'b1;
    send(2'b01, mk(16'h7, 16'h70), '0, 2'b11, 2'b00);
    total++; if (link_alive !== 2'b01) $display("FAIL wd_start got %b want 01", link_alive); else pass++;
    repeat (99) tick();
    total++; if (link_alive !== 2'b01) $display("FAIL wd_99 got %b want 01", link_alive); else pass++;
    tick();
    total++; if (link_alive !== 2'b00) $display("FAIL wd_100 got %b want 00", link_alive); else pass++;
    repeat (5) tick();
    total++; if (link_alive !== 2'b00) $display("FAIL wd_dead got %b want 00", link_alive); else pass++;
    send(2'b01, mk(16'h8, 16'h80), '0, 2'b11, 2'b00);
    total++; if (link_alive !== 2'b01) $display("FAIL wd_revive got %b want 01", link_alive); else pass++;
    tick();
    total++; if (out_valid !== 1'b1 || out_frame !== mk(16'h8, 16'h80)) $display("FAIL wd_forward got %b/%h want 1/%h", out_valid, out_frame, mk(16'h8, 16'h80)); else pass++;
    out_ready = 1'b0;
  endtask
  task automatic test_reset_mid_offer();
    do_reset();
    send(2'b01, mk(16'h9, 16'h90), '0, 2'b01, 2'b00);
    send(2'b01, mk(16'hA0, 16'hA0), '0, 2'b01, 2'b00);
    total++; if (out_valid !== 1'b1) $display("FAIL mid_pre got %b want 1", out_valid); else pass++;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL mid_async got %b want 0", out_valid); else pass++;
    total++; if (out_frame !== '0) $display("FAIL mid_frame got %h want 0", out_frame); else pass++;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    total++; if (out_valid !== 1'b0) $display("FAIL mid_lost got %b want 0", out_valid); else pass++;
    send(2'b01, mk(16'hB0, 16'hB0), '0, 2'b10, 2'b00);
    tick();
    total++; if (out_valid !== 1'b1 || out_frame !== mk(16'hB0, 16'hB0)) $display("FAIL mid_new got %b/%h want 1/%h", out_valid, out_frame, mk(16'hB0, 16'hB0)); else pass++;
  endtask
  initial begin
    test_reset();
    test_latency();
    test_overrun();
    test_round_robin();
    test_back_to_back();
    test_watchdog();
    test_reset_mid_offer();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
